multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
Multi-cycle control FSM for the RV32I core. It sequences fetch, decode, execute, memory and writeback for R, I-ALU, load, store and branch instructions. It drives the enables and selects for the PC, IR, register file, ALU operand mux and data memory, and handshakes with instruction and data memory. The immediate generator and ALU are pure datapath; this block decides when their results are used.

Parameters:
WAIT_MAX, 255, maximum cycles a memory request may stay pending before TRAP; 0 disables the timeout.
CNT_W, 8, width of the wait counter; must satisfy 2^CNT_W > WAIT_MAX.

Ports:
clk  in  1  core clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
instruction  in  32  current IR contents (opcode [6:0], funct3 [14:12], funct7 [31:25]).
imem_req  out  1  instruction fetch request.
imem_ready  in  1  fetch data valid this cycle.
dmem_req  out  1  data memory request.
dmem_we  out  1  1 = store, 0 = load; valid only while dmem_req = 1.
dmem_ready  in  1  data access complete this cycle.
branch_taken  in  1  ALU compare result for the current branch.
ir_we  out  1  load IR, single-cycle pulse.
pc_we  out  1  update PC, single-cycle pulse.
pc_src  out  1  0 = PC+4, 1 = PC+imm.
alu_src_b  out  1  1 = immediate from imm_gen, 0 = rs2.
alu_ctrl  out  2  00 = ADD, 01 = SUB/compare, 10 = decode funct3/funct7.
rf_we  out  1  register file write, single-cycle pulse.
mem_to_reg  out  1  1 = writeback data comes from dmem.
state  out  3  current FSM state, for debug.
illegal  out  1  sticky: an illegal opcode was seen.
timeout  out  1  sticky: a memory wait exceeded WAIT_MAX.

Behaviour:
- Reset (asynchronous): state = FETCH. All outputs are 0, including the sticky flags and the wait counter. While rst_n = 0, imem_req = 0.
- Outputs are decoded from the registered state and the IR (Moore style). No output depends combinationally on imem_ready or dmem_ready, except ir_we, pc_we and rf_we, which are gated by ready where stated below.
- FETCH:
  - imem_req = 1.
  - On imem_ready = 1: ir_we = 1 and go to DECODE. Otherwise stay.
- DECODE (1 cycle): classify opcode.
  - 0110011 = R, 0010011 = I-ALU, 0000011 = LOAD, 0100011 = STORE, 1100011 = BRANCH.
  - Any other opcode goes to TRAP.
- EXEC (1 cycle):
  - R: alu_src_b = 0, alu_ctrl = 10, go to WB.
  - I-ALU: alu_src_b = 1, alu_ctrl = 10, go to WB.
  - LOAD/STORE: alu_src_b = 1, alu_ctrl = 00, go to MEM.
  - BRANCH: alu_src_b = 0, alu_ctrl = 01, pc_we = 1, pc_src = branch_taken, go to FETCH.
- MEM:
  - dmem_req = 1; dmem_we = 1 for STORE.
  - alu_src_b = 1 and alu_ctrl = 00 are held, so the address stays stable.
  - On dmem_ready: STORE pulses pc_we with pc_src = 0 and goes to FETCH; LOAD goes to WB.
- WB (1 cycle):
  - rf_we = 1, pc_we = 1, pc_src = 0.
  - mem_to_reg = 1 for LOAD.
  - Go to FETCH.
- TRAP: terminal. All request and enable outputs are 0. Only reset exits TRAP.
- Handshake rules:
  - A request is held high until ready is sampled high.
  - Ready is ignored while the matching request is low.
  - Ready in the same cycle the request rises completes that cycle.
- Wait counter:
  - Clears on entry to FETCH and to MEM, and increments each cycle a request stays pending.
  - With WAIT_MAX > 0, when count == WAIT_MAX and ready = 0: set timeout and go to TRAP.
  - Ready arriving in the WAIT_MAX-th cycle wins over the timeout.
- Decoding illegal sets the illegal flag in the same transition as the move to TRAP.
- Latency per instruction, with zero-wait memory: branch 3 cycles; R / I-ALU / store 4 cycles; load 5 cycles.

Optional Feature:
CTRL_PERF_EN.
- Defined: adds output ports cycle_cnt[31:0] and instret_cnt[31:0].
  - cycle_cnt increments every cycle outside TRAP.
  - instret_cnt increments on every pc_we pulse.
  - Both wrap modulo 2^32 and reset to 0.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Package ctrl_pkg holds:
  - state_t enum {FETCH, DECODE, EXEC, MEM, WB, TRAP}, encoded 0 to 5;
  - opcode localparams OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH;
  - alu_ctrl_t {ALU_ADD, ALU_SUB, ALU_FUNCT};
  - pc_src localparams PC_PLUS4, PC_TARGET.
- One sub-module, ctrl_wait_timer: holds the wait counter, with clear/enable inputs, a parameterised WAIT_MAX, and an expired output.

Test Plan:
- addi x1,x0,5 (0x00500093), imem_ready tied 1 -> states 0,1,2,4; alu_src_b = 1 in EXEC; rf_we and pc_we high together in cycle 4, pc_src = 0.
- lw x2,0(x1) (0x0000a103), dmem_ready high 3 cycles after dmem_req -> dmem_req = 1 and dmem_we = 0 for 4 cycles, then WB with mem_to_reg = 1; 8 cycles total.
- beq x0,x0,+8 (0x00000463) with branch_taken = 1 -> pc_we and pc_src = 1 in EXEC, back in FETCH on cycle 4; repeat with branch_taken = 0 -> pc_src = 0.
- Instruction 0xFFFFFFFF -> DECODE goes to TRAP; illegal = 1; imem_req stays 0 for the following 10 cycles.
- WAIT_MAX = 4, imem_ready held 0 -> imem_req high 4 cycles, then timeout = 1 and state = 5; repeat with ready on the 4th cycle -> normal DECODE.
- sw (0x0020a023) with rst_n dropped mid-MEM -> all outputs 0 immediately (asynchronous); after release, imem_req = 1 in FETCH.

Source files
------------

// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared states, opcodes and encodings for the multicycle control FSM
package ctrl_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10
  } alu_ctrl_t;

  localparam logic PC_PLUS4  = 1'b0;
  localparam logic PC_TARGET = 1'b1;

  function automatic logic is_legal(input logic [6:0] op);
    return (op == OP_R) || (op == OP_IMM) || (op == OP_LOAD) ||
           (op == OP_STORE) || (op == OP_BRANCH);
  endfunction

endpackage

// File: rtl/ctrl_wait_timer.sv
// rtl/ctrl_wait_timer.sv - memory wait counter that flags the WAIT_MAX-th pending cycle
module ctrl_wait_timer #(
  parameter int unsigned WAIT_MAX = 255,
  parameter int unsigned CNT_W    = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic expired
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // cnt_q counts completed waits, so the current pending cycle is number cnt_q+1
  generate
    if (WAIT_MAX == 0) begin : g_no_timeout
      assign expired = 1'b0;
    end else begin : g_timeout
      localparam logic [CNT_W-1:0] LAST = CNT_W'(WAIT_MAX - 1);
      assign expired = en && (cnt_q == LAST);
    end
  endgenerate

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - RV32I multicycle control FSM; CTRL_PERF_EN adds cycle/instret counters
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 255,
  parameter int unsigned CNT_W    = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instruction,
  output logic        imem_req,
  input  logic        imem_ready,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ready,
  input  logic        branch_taken,
  output logic        ir_we,
  output logic        pc_we,
  output logic        pc_src,
  output logic        alu_src_b,
  output logic [1:0]  alu_ctrl,
  output logic        rf_we,
  output logic        mem_to_reg,
  output logic [2:0]  state,
  output logic        illegal,
  output logic        timeout
`ifdef CTRL_PERF_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt
`endif
);

  state_t     state_q, state_d;
  logic       illegal_q, timeout_q;
  logic       set_illegal, set_timeout;
  logic       pending, timer_clear, expired;
  logic [6:0] opcode;
  logic       unused_instr_bits;

  assign opcode = instruction[6:0];
  // funct fields are consumed by the ALU decoder, not by this FSM
  assign unused_instr_bits = ^instruction[31:7];

  assign pending     = ((state_q == FETCH) && !imem_ready) ||
                       ((state_q == MEM) && !dmem_ready);
  assign timer_clear = (state_d != state_q) && ((state_d == FETCH) || (state_d == MEM));

  ctrl_wait_timer #(
    .WAIT_MAX (WAIT_MAX),
    .CNT_W    (CNT_W)
  ) u_wait_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (timer_clear),
    .en      (pending),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FETCH;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (set_illegal) illegal_q <= 1'b1;
      if (set_timeout) timeout_q <= 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    set_illegal = 1'b0;
    set_timeout = 1'b0;
    imem_req    = 1'b0;
    ir_we       = 1'b0;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    pc_we       = 1'b0;
    pc_src      = PC_PLUS4;
    alu_src_b   = 1'b0;
    alu_ctrl    = ALU_ADD;
    rf_we       = 1'b0;
    mem_to_reg  = 1'b0;
    case (state_q)
      FETCH: begin
        // reset parks the FSM in FETCH, so the request must be masked by rst_n
        imem_req = rst_n;
        if (imem_ready) begin
          ir_we   = rst_n;
          state_d = DECODE;
        end else if (expired) begin
          set_timeout = 1'b1;
          state_d     = TRAP;
        end
      end
      DECODE: begin
        if (is_legal(opcode)) begin
          state_d = EXEC;
        end else begin
          set_illegal = 1'b1;
          state_d     = TRAP;
        end
      end
      EXEC: begin
        case (opcode)
          OP_R: begin
            alu_ctrl = ALU_FUNCT;
            state_d  = WB;
          end
          OP_IMM: begin
            alu_src_b = 1'b1;
            alu_ctrl  = ALU_FUNCT;
            state_d   = WB;
          end
          OP_LOAD, OP_STORE: begin
            alu_src_b = 1'b1;
            state_d   = MEM;
          end
          OP_BRANCH: begin
            alu_ctrl = ALU_SUB;
            pc_we    = 1'b1;
            pc_src   = branch_taken ? PC_TARGET : PC_PLUS4;
            state_d  = FETCH;
          end
          default: state_d = TRAP;
        endcase
      end
      MEM: begin
        dmem_req  = 1'b1;
        dmem_we   = (opcode == OP_STORE);
        alu_src_b = 1'b1;
        if (dmem_ready) begin
          if (opcode == OP_STORE) begin
            pc_we   = 1'b1;
            state_d = FETCH;
          end else begin
            state_d = WB;
          end
        end else if (expired) begin
          set_timeout = 1'b1;
          state_d     = TRAP;
        end
      end
      WB: begin
        rf_we      = 1'b1;
        pc_we      = 1'b1;
        mem_to_reg = (opcode == OP_LOAD);
        state_d    = FETCH;
      end
      TRAP:    state_d = TRAP;
      default: state_d = TRAP;
    endcase
  end

  assign state   = state_q;
  assign illegal = illegal_q;
  assign timeout = timeout_q;

`ifdef CTRL_PERF_EN
  logic [31:0] cycle_q, instret_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      if (state_q != TRAP) cycle_q <= cycle_q + 32'd1;
      if (pc_we) instret_q <= instret_q + 32'd1;
    end
  end

  assign cycle_cnt   = cycle_q;
  assign instret_cnt = instret_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - directed self-checking bench for multicycle_ctrl (WAIT_MAX = 4)
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instruction;
  logic        imem_req, imem_ready;
  logic        dmem_req, dmem_we, dmem_ready;
  logic        branch_taken;
  logic        ir_we, pc_we, pc_src, alu_src_b;
  logic [1:0]  alu_ctrl;
  logic        rf_we, mem_to_reg;
  logic [2:0]  state;
  logic        illegal, timeout;
`ifdef CTRL_PERF_EN
  logic [31:0] cycle_cnt, instret_cnt;
`endif

  int vectors = 0;
  int miscompares = 0;

  // control word: imem_req ir_we dmem_req dmem_we pc_we pc_src alu_src_b alu_ctrl[1:0] rf_we mem_to_reg
  localparam logic [10:0] C_NONE   = 11'b00000000000;
  localparam logic [10:0] C_F_RDY  = 11'b11000000000;
  localparam logic [10:0] C_F_WAIT = 11'b10000000000;
  localparam logic [10:0] C_E_RI   = 11'b00000011000;
  localparam logic [10:0] C_E_I    = 11'b00000011000;
  localparam logic [10:0] C_E_R    = 11'b00000001000;
  localparam logic [10:0] C_E_LS   = 11'b00000010000;
  localparam logic [10:0] C_E_BT   = 11'b00001100100;
  localparam logic [10:0] C_E_BN   = 11'b00001000100;
  localparam logic [10:0] C_M_LD   = 11'b00100010000;
  localparam logic [10:0] C_M_ST   = 11'b00110010000;
  localparam logic [10:0] C_M_STOK = 11'b00111010000;
  localparam logic [10:0] C_WB     = 11'b00001000010;
  localparam logic [10:0] C_WB_LD  = 11'b00001000011;

  localparam logic [31:0] I_ADDI = 32'h00500093;
  localparam logic [31:0] I_ADD  = 32'h002081b3;
  localparam logic [31:0] I_LW   = 32'h0000a103;
  localparam logic [31:0] I_BEQ  = 32'h00000463;
  localparam logic [31:0] I_SW   = 32'h0020a023;
  localparam logic [31:0] I_BAD  = 32'hffffffff;

  multicycle_ctrl #(
    .WAIT_MAX (4),
    .CNT_W    (8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .instruction  (instruction),
    .imem_req     (imem_req),
    .imem_ready   (imem_ready),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_ready   (dmem_ready),
    .branch_taken (branch_taken),
    .ir_we        (ir_we),
    .pc_we        (pc_we),
    .pc_src       (pc_src),
    .alu_src_b    (alu_src_b),
    .alu_ctrl     (alu_ctrl),
    .rf_we        (rf_we),
    .mem_to_reg   (mem_to_reg),
    .state        (state),
    .illegal      (illegal),
    .timeout      (timeout)
`ifdef CTRL_PERF_EN
    ,
    .cycle_cnt    (cycle_cnt),
    .instret_cnt  (instret_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_now(input string tag, input logic [2:0] st,
                           input logic [10:0] ctl, input logic [1:0] flg);
    logic [15:0] obs, exp;
    obs = {state, imem_req, ir_we, dmem_req, dmem_we, pc_we, pc_src,
           alu_src_b, alu_ctrl, rf_we, mem_to_reg, illegal, timeout};
    exp = {st, ctl, flg};
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%04h expected=%04h", tag, obs, exp);
    end
  endtask

  // inputs are set at a falling edge; check 1ns later, then move to the next falling edge
  task automatic step(input string tag, input logic [2:0] st,
                      input logic [10:0] ctl, input logic [1:0] flg);
    #1;
    check_now(tag, st, ctl, flg);
    @(negedge clk);
  endtask

  initial begin
    rst_n        = 1'b0;
    instruction  = I_ADDI;
    imem_ready   = 1'b1;
    dmem_ready   = 1'b0;
    branch_taken = 1'b0;
    @(negedge clk);
    #1;
    check_now("reset", 3'd0, C_NONE, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;

    // addi with zero-wait fetch: 4 cycles
    step("addi_fetch",  3'd0, C_F_RDY, 2'b00);
    step("addi_decode", 3'd1, C_NONE,  2'b00);
    step("addi_exec",   3'd2, C_E_I,   2'b00);
    step("addi_wb",     3'd4, C_WB,    2'b00);

    // R-type
    instruction = I_ADD;
    step("add_fetch", 3'd0, C_F_RDY, 2'b00);
    step("add_dec",   3'd1, C_NONE,  2'b00);
    step("add_exec",  3'd2, C_E_R,   2'b00);
    step("add_wb",    3'd4, C_WB,    2'b00);

    // lw with dmem_ready on the 4th MEM cycle: 8 cycles
    instruction = I_LW;
    step("lw_fetch", 3'd0, C_F_RDY, 2'b00);
    step("lw_dec",   3'd1, C_NONE,  2'b00);
    step("lw_exec",  3'd2, C_E_LS,  2'b00);
    step("lw_mem1",  3'd3, C_M_LD,  2'b00);
    step("lw_mem2",  3'd3, C_M_LD,  2'b00);
    step("lw_mem3",  3'd3, C_M_LD,  2'b00);
    dmem_ready = 1'b1;
    step("lw_mem4",  3'd3, C_M_LD,  2'b00);
    dmem_ready = 1'b0;
    step("lw_wb",    3'd4, C_WB_LD, 2'b00);

    // beq taken then not taken: 3 cycles each
    instruction  = I_BEQ;
    branch_taken = 1'b1;
    step("beqt_fetch", 3'd0, C_F_RDY, 2'b00);
    step("beqt_dec",   3'd1, C_NONE,  2'b00);
    step("beqt_exec",  3'd2, C_E_BT,  2'b00);
    branch_taken = 1'b0;
    step("beqn_fetch", 3'd0, C_F_RDY, 2'b00);
    step("beqn_dec",   3'd1, C_NONE,  2'b00);
    step("beqn_exec",  3'd2, C_E_BN,  2'b00);

    // sw, dmem_ready held high throughout; it must only matter in MEM
    instruction = I_SW;
    dmem_ready  = 1'b1;
    step("sw_fetch", 3'd0, C_F_RDY,  2'b00);
    step("sw_dec",   3'd1, C_NONE,   2'b00);
    step("sw_exec",  3'd2, C_E_LS,   2'b00);
    step("sw_mem",   3'd3, C_M_STOK, 2'b00);
    dmem_ready = 1'b0;

    // sw with asynchronous reset mid-MEM
    step("swr_fetch", 3'd0, C_F_RDY, 2'b00);
    step("swr_dec",   3'd1, C_NONE,  2'b00);
    step("swr_exec",  3'd2, C_E_LS,  2'b00);
    #1;
    check_now("swr_mem", 3'd3, C_M_ST, 2'b00);
    #2;
    rst_n = 1'b0;
    #1;
    check_now("swr_async_rst", 3'd0, C_NONE, 2'b00);
    @(negedge clk);
    rst_n      = 1'b1;
    imem_ready = 1'b0;

    // fetch timeout: imem_req for 4 cycles, then TRAP with timeout
    step("to_f1", 3'd0, C_F_WAIT, 2'b00);
    step("to_f2", 3'd0, C_F_WAIT, 2'b00);
    step("to_f3", 3'd0, C_F_WAIT, 2'b00);
    step("to_f4", 3'd0, C_F_WAIT, 2'b00);
    imem_ready = 1'b1;
    step("to_trap1", 3'd5, C_NONE, 2'b01);
    step("to_trap2", 3'd5, C_NONE, 2'b01);

    // ready in the 4th pending cycle wins over the timeout
    rst_n = 1'b0;
    #1;
    check_now("rst_clears_timeout", 3'd0, C_NONE, 2'b00);
    @(negedge clk);
    rst_n       = 1'b1;
    imem_ready  = 1'b0;
    instruction = I_ADDI;
    step("rw_f1", 3'd0, C_F_WAIT, 2'b00);
    step("rw_f2", 3'd0, C_F_WAIT, 2'b00);
    step("rw_f3", 3'd0, C_F_WAIT, 2'b00);
    imem_ready = 1'b1;
    step("rw_f4",   3'd0, C_F_RDY, 2'b00);
    step("rw_dec",  3'd1, C_NONE,  2'b00);
    step("rw_exec", 3'd2, C_E_I,   2'b00);
    step("rw_wb",   3'd4, C_WB,    2'b00);

    // illegal opcode: TRAP and illegal, no further fetches
    instruction = I_BAD;
    step("ill_fetch", 3'd0, C_F_RDY, 2'b00);
    step("ill_dec",   3'd1, C_NONE,  2'b00);
    for (int i = 0; i < 10; i++) begin
      step($sformatf("ill_trap%0d", i), 3'd5, C_NONE, 2'b10);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
